// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared types and constants for the PS/2 scan-code receiver.
//   frame_state_e      : device-to-host frame FSM states
//   PS2_BREAK_PREFIX   : F0, announces that the next code is a key release
//   PS2_EXT_PREFIX     : E0, announces that the next code is an extended key
//   KEY_W/A/S/D        : make codes of the game movement keys
//   ps2_odd_parity_ok  : true when data plus parity bit hold an odd number of 1s
// ----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_e;

    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;

    localparam logic [7:0] KEY_W = 8'h1D;
    localparam logic [7:0] KEY_A = 8'h1C;
    localparam logic [7:0] KEY_S = 8'h1B;
    localparam logic [7:0] KEY_D = 8'h23;

    function automatic logic ps2_odd_parity_ok(input logic [7:0] data,
                                               input logic       par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// ----------------------------------------------------------------------------
// ps2_scancode_rx_if
// Bundles the raw PS/2 lines and the decoded scan-code outputs.
//   PS2_CLK, PS2_DAT : raw PS/2 bus, driven by the device (master side)
//   valid            : one-cycle pulse, a complete non-prefix code is ready
//   makeBreak        : 1 = press, 0 = release (held)
//   outCode[7:0]     : scan code (held)
//   extended         : code was preceded by E0 (held)
//   frame_err        : one-cycle pulse on a bad frame or a timeout
// Modports: master = keyboard/driver side, slave = receiver side.
// ----------------------------------------------------------------------------
interface ps2_scancode_rx_if;

    logic       PS2_CLK;
    logic       PS2_DAT;
    logic       valid;
    logic       makeBreak;
    logic [7:0] outCode;
    logic       extended;
    logic       frame_err;

    modport master (
        output PS2_CLK, PS2_DAT,
        input  valid, makeBreak, outCode, extended, frame_err
    );

    modport slave (
        input  PS2_CLK, PS2_DAT,
        output valid, makeBreak, outCode, extended, frame_err
    );

endinterface

// File: rtl/ps2_frame_rx.sv
// ----------------------------------------------------------------------------
// ps2_frame_rx
// Synchronises the raw PS/2 lines, detects PS2_CLK falling edges and
// assembles 11-bit device-to-host frames (start, D0..D7, odd parity, stop).
// Optional build macro: PS2_PARITY_CHECK_EN -- when defined a frame with bad
// parity is rejected with frame_err; otherwise the parity bit is ignored.
// Ports:
//   clk, reset   : system clock, asynchronous active-high reset
//   ps2_clk_i    : raw PS/2 clock (asynchronous)
//   ps2_dat_i    : raw PS/2 data (asynchronous)
//   byte_rdy_o   : one-cycle strobe, byte_o holds a good byte
//   byte_o[7:0]  : received byte, valid while byte_rdy_o is high
//   frame_err_o  : one-cycle strobe on bad stop/parity or timeout
//   timeout_o    : one-cycle strobe when a partial frame is aborted
// ----------------------------------------------------------------------------
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,       // must be >= 2
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       byte_rdy_o,
    output logic [7:0] byte_o,
    output logic       frame_err_o,
    output logic       timeout_o
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_prev_q;

    frame_state_e state_q;
    logic [2:0]   bit_cnt_q;
    logic [7:0]   shift_q;
    logic         par_q;
    logic [TW-1:0] to_cnt_q;

    logic clk_cur;
    logic dat_cur;
    logic fall;
    logic timeout;
    logic parity_good;
    logic stop_seen;

    // Synchronizers idle at 1 so reset never fabricates a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign clk_cur = clk_sync_q[SYNC_STAGES-1];
    assign dat_cur = dat_sync_q[SYNC_STAGES-1];
    assign fall    = clk_prev_q & ~clk_cur;

`ifdef PS2_PARITY_CHECK_EN
    assign parity_good = ps2_odd_parity_ok(shift_q, par_q);
`else
    logic parity_unused;
    assign parity_unused = par_q;
    assign parity_good   = 1'b1;
`endif

    // An edge in the same cycle beats the timeout.
    assign timeout   = (state_q != IDLE) && !fall && (to_cnt_q == TIMEOUT_LAST);
    assign stop_seen = fall && (state_q == STOP);

    // Strobes are decoded straight from the edge cycle so the top can
    // register valid exactly one clock after the stop edge.
    assign byte_rdy_o  = stop_seen && dat_cur && parity_good;
    assign frame_err_o = (stop_seen && !(dat_cur && parity_good)) || timeout;
    assign timeout_o   = timeout;
    assign byte_o      = shift_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            if (state_q == IDLE || fall) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end

            if (timeout) begin
                state_q <= IDLE;
            end else if (fall) begin
                case (state_q)
                    IDLE: begin
                        // A high level here is a glitch, not a start bit.
                        if (!dat_cur) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        // LSB arrives first, so shifting in at the top
                        // leaves D0 in bit 0 after eight bits.
                        shift_q   <= {dat_cur, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_q   <= dat_cur;
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// ----------------------------------------------------------------------------
// ps2_scancode_rx
// Receives PS/2 keyboard frames and folds the F0 (break) and E0 (extended)
// prefixes into the following code. Emits a one-cycle valid pulse together
// with held outCode / makeBreak / extended values.
// Optional build macro: PS2_PARITY_CHECK_EN (parity checking in ps2_frame_rx).
// Ports:
//   clk   : system clock
//   reset : asynchronous active-high reset
//   ps2   : ps2_scancode_rx_if.slave (PS2_CLK/PS2_DAT in; valid, makeBreak,
//           outCode, extended, frame_err out)
// ----------------------------------------------------------------------------
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              reset,
    ps2_scancode_rx_if.slave  ps2
);

    logic       byte_rdy;
    logic [7:0] rx_byte;
    logic       rx_err;
    logic       rx_timeout;

    logic       valid_q;
    logic       make_break_q;
    logic [7:0] out_code_q;
    logic       extended_q;
    logic       frame_err_q;
    logic       brk_pend_q;
    logic       ext_pend_q;

    ps2_frame_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk_i   (ps2.PS2_CLK),
        .ps2_dat_i   (ps2.PS2_DAT),
        .byte_rdy_o  (byte_rdy),
        .byte_o      (rx_byte),
        .frame_err_o (rx_err),
        .timeout_o   (rx_timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            make_break_q <= 1'b0;
            out_code_q   <= '0;
            extended_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            brk_pend_q   <= 1'b0;
            ext_pend_q   <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= rx_err;

            // A timeout leaves the prefix sequence in doubt, so drop it.
            // Bad stop/parity frames keep pending prefixes.
            if (rx_timeout) begin
                brk_pend_q <= 1'b0;
                ext_pend_q <= 1'b0;
            end

            if (byte_rdy) begin
                case (rx_byte)
                    PS2_BREAK_PREFIX: brk_pend_q <= 1'b1;
                    PS2_EXT_PREFIX:   ext_pend_q <= 1'b1;
                    default: begin
                        valid_q      <= 1'b1;
                        out_code_q   <= rx_byte;
                        make_break_q <= ~brk_pend_q;
                        extended_q   <= ext_pend_q;
                        brk_pend_q   <= 1'b0;
                        ext_pend_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ps2.valid     = valid_q;
    assign ps2.makeBreak = make_break_q;
    assign ps2.outCode   = out_code_q;
    assign ps2.extended  = extended_q;
    assign ps2.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// ----------------------------------------------------------------------------
// tb_ps2_scancode_rx
// Directed bench: drives PS/2 frames bit by bit and checks the decoded
// outputs, pulse counts and the stop-edge-to-valid latency.
// ----------------------------------------------------------------------------
module tb_ps2_scancode_rx;
    import ps2_pkg::*;

    localparam int HALF = 40;     // PS2_CLK half period in clk cycles

    logic clk = 1'b0;
    logic reset;

    always #10 clk = ~clk;        // 50 MHz

    ps2_scancode_rx_if bus ();

    ps2_scancode_rx #(
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ps2   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int v0;
    int e0;

    always @(negedge clk) begin
        if (bus.valid === 1'b1)     valid_cnt <= valid_cnt + 1;
        if (bus.frame_err === 1'b1) err_cnt   <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        bus.PS2_DAT = b;
        repeat (HALF) @(negedge clk);
        bus.PS2_CLK = 1'b0;
        repeat (HALF) @(negedge clk);
        bus.PS2_CLK = 1'b1;
    endtask

    // Start, eight data bits and parity; bad_par flips to even parity.
    task automatic frame_head(input logic [7:0] d, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ bad_par);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par);
        frame_head(d, bad_par);
        ps2_bit(1'b1);
        $display("frame %02h bad_par=%0b -> valid=%0d err=%0d code=%02h mb=%0b ext=%0b",
                 d, bad_par, valid_cnt, err_cnt, bus.outCode, bus.makeBreak, bus.extended);
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] code,
                                 input logic mb, input logic ext);
        check({tag, "_code"}, 32'(bus.outCode), 32'(code));
        check({tag, "_mb"},   32'(bus.makeBreak), 32'(mb));
        check({tag, "_ext"},  32'(bus.extended), 32'(ext));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        bus.PS2_CLK = 1'b1;
        bus.PS2_DAT = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Reset state
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_err",   32'(bus.frame_err), 32'd0);
        check_outputs("rst", 8'h00, 1'b0, 1'b0);

        // Single 1D with exact latency from the stop edge
        v0 = valid_cnt;
        frame_head(KEY_W, 1'b0);
        bus.PS2_DAT = 1'b1;
        repeat (HALF) @(negedge clk);
        bus.PS2_CLK = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("lat_early", 32'(bus.valid), 32'd0);
        @(posedge clk);
        #1 check("lat_pulse", 32'(bus.valid), 32'd1);
        @(posedge clk);
        #1 check("lat_after", 32'(bus.valid), 32'd0);
        repeat (HALF) @(negedge clk);
        bus.PS2_CLK = 1'b1;
        $display("frame 1d latency test -> valid=%0d", valid_cnt);
        check("w_count", 32'(valid_cnt - v0), 32'd1);
        check_outputs("w", KEY_W, 1'b1, 1'b0);

        // F0 1D : release
        v0 = valid_cnt;
        send_frame(8'hF0, 1'b0);
        check("brk_pfx_novalid", 32'(valid_cnt - v0), 32'd0);
        send_frame(KEY_W, 1'b0);
        check("brk_count", 32'(valid_cnt - v0), 32'd1);
        check_outputs("brk", KEY_W, 1'b0, 1'b0);

        // E0 F0 75 then 1C
        v0 = valid_cnt;
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        check("ext_count", 32'(valid_cnt - v0), 32'd1);
        check_outputs("ext", 8'h75, 1'b0, 1'b1);
        send_frame(KEY_A, 1'b0);
        check_outputs("after_ext", KEY_A, 1'b1, 1'b0);

        // Bad parity 1C preceded by 1B
        send_frame(KEY_S, 1'b0);
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(KEY_A, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        check("par_err",   32'(err_cnt - e0), 32'd1);
        check("par_valid", 32'(valid_cnt - v0), 32'd0);
        check("par_code",  32'(bus.outCode), 32'(KEY_S));
`else
        check("par_err",   32'(err_cnt - e0), 32'd0);
        check("par_valid", 32'(valid_cnt - v0), 32'd1);
        check("par_code",  32'(bus.outCode), 32'(KEY_A));
`endif

        // F0, then a partial frame that times out; the prefix must be dropped
        send_frame(8'hF0, 1'b0);
        v0 = valid_cnt;
        e0 = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        bus.PS2_DAT = 1'b1;
        repeat (300) @(negedge clk);
        $display("partial frame + silence -> err=%0d", err_cnt);
        check("to_err",   32'(err_cnt - e0), 32'd1);
        check("to_valid", 32'(valid_cnt - v0), 32'd0);
        send_frame(KEY_D, 1'b0);
        check("to_next_count", 32'(valid_cnt - v0), 32'd1);
        check_outputs("to_next", KEY_D, 1'b1, 1'b0);

        // F0, then reset in the middle of the next frame
        send_frame(8'hF0, 1'b0);
        e0 = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(KEY_S[i]);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        bus.PS2_DAT = 1'b1;
        repeat (300) @(negedge clk);
        $display("reset mid-frame -> code=%02h mb=%0b ext=%0b",
                 bus.outCode, bus.makeBreak, bus.extended);
        check("mrst_valid", 32'(bus.valid), 32'd0);
        check("mrst_noerr", 32'(err_cnt - e0), 32'd0);
        check_outputs("mrst", 8'h00, 1'b0, 1'b0);
        v0 = valid_cnt;
        send_frame(KEY_S, 1'b0);
        check("mrst_next_count", 32'(valid_cnt - v0), 32'd1);
        check_outputs("mrst_next", KEY_S, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
